// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one fetch at a time to instruction
// memory and holds the returned word until decode accepts it, then redirects on branch/jump.
module instruction_fetch_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              IMemReq,
   output logic [ADDR_W-1:0] IMemAddr,
   input  logic              IMemValid,
   input  logic [31:0]       IMemData,
   output logic [31:0]       Instr,
   output logic [5:0]        Opcode,
   output logic              InstrValid,
   output logic [ADDR_W-1:0] PCOut,
   input  logic              DecReady,
   input  logic              Branch,
   input  logic              Zero,
   input  logic [15:0]       BranchOffset,
   input  logic              Jump,
   input  logic [25:0]       JumpTarget
);

   // state  | meaning
   // S_REQ  | strobe IMemReq with IMemAddr=pc (first cycle after reset only loads the strobe)
   // S_WAIT | one fetch outstanding; capture IMemData on IMemValid
   // S_HOLD | Instr presented to decode until DecReady; pc already holds PCOut+4
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] offset_ext;
   logic [ADDR_W-1:0] branch_pc;
   logic [ADDR_W-1:0] jump_pc;
   logic [ADDR_W-1:0] next_pc;

   assign Opcode = Instr[31:26];

   // In HOLD pc equals PCOut+4, so both redirect targets are formed from pc directly.
   assign offset_ext = {{(ADDR_W-18){BranchOffset[15]}}, BranchOffset, 2'b00};
   assign branch_pc  = pc + offset_ext;
   assign jump_pc    = {pc[ADDR_W-1:28], JumpTarget, 2'b00};

   always_comb begin
      next_pc = pc;
      if (Jump) begin
         next_pc = jump_pc;
      end else if (Branch && Zero) begin
         next_pc = branch_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_REQ;
         pc         <= RESET_PC;
         IMemReq    <= 1'b0;
         IMemAddr   <= '0;
         Instr      <= '0;
         InstrValid <= 1'b0;
         PCOut      <= '0;
      end else begin
         case (state)
            S_REQ: begin
               if (IMemReq) begin
                  IMemReq <= 1'b0;
                  state   <= S_WAIT;
               end else begin
                  IMemReq  <= 1'b1;
                  IMemAddr <= pc;
               end
            end
            S_WAIT: begin
               if (IMemValid) begin
                  Instr      <= IMemData;
                  PCOut      <= pc;
                  InstrValid <= 1'b1;
                  pc         <= pc + ADDR_W'(4);
                  state      <= S_HOLD;
               end
            end
            S_HOLD: begin
               // The next request is launched on the accepting edge so REQ lasts one cycle.
               if (DecReady) begin
                  InstrValid <= 1'b0;
                  pc         <= next_pc;
                  IMemReq    <= 1'b1;
                  IMemAddr   <= next_pc;
                  state      <= S_REQ;
               end
            end
            default: begin
               state   <= S_REQ;
               IMemReq <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a memory responder, a decode driver and a
// monitor that predicts the fetch address stream from the branch/jump rules.
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk;
   logic        reset;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemValid;
   logic [31:0] IMemData;
   logic [31:0] Instr;
   logic [5:0]  Opcode;
   logic        InstrValid;
   logic [31:0] PCOut;
   logic        DecReady;
   logic        Branch;
   logic        Zero;
   logic [15:0] BranchOffset;
   logic        Jump;
   logic [25:0] JumpTarget;

   instruction_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .IMemReq(IMemReq), .IMemAddr(IMemAddr),
      .IMemValid(IMemValid), .IMemData(IMemData),
      .Instr(Instr), .Opcode(Opcode), .InstrValid(InstrValid), .PCOut(PCOut),
      .DecReady(DecReady), .Branch(Branch), .Zero(Zero), .BranchOffset(BranchOffset),
      .Jump(Jump), .JumpTarget(JumpTarget)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Memory contents are a fixed function of the address; address 0 holds 0.
   function automatic logic [31:0] mem_word(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
   endfunction

   function automatic logic [31:0] next_fetch(logic [31:0] pc, logic j, logic br, logic z,
                                              logic [15:0] off, logic [25:0] tgt);
      logic [31:0] seq;
      int          words;
      seq   = pc + 32'd4;
      words = int'($signed(off));
      if (j) return (seq & 32'hF000_0000) + 32'(tgt) * 32'd4;
      if (br && z) return seq + 32'(words * 4);
      return seq;
   endfunction

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Control variables written only by the main process.
   int          mem_lat_min = 1;
   int          mem_lat_max = 1;
   int          stale_cmd   = 0;
   int          dir_seq     = 0;
   logic [31:0] dir_exp     = 32'h0;
   int          tmo_count   = 0;

   // Instruction memory responder; drives #2 after the edge so it sees main's #1 updates.
   initial begin : memory
      int          mem_cnt;
      int          stale_done;
      logic [31:0] mem_addr;
      bit          stale_now;
      mem_cnt    = 0;
      stale_done = 0;
      stale_now  = 1'b0;
      mem_addr   = 32'h0;
      IMemValid  = 1'b0;
      IMemData   = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         IMemValid = 1'b0;
         IMemData  = $urandom;
         if (reset) begin
            mem_cnt = 0;
         end else begin
            if (stale_now) begin
               IMemValid = 1'b1;
               IMemData  = 32'hDEAD_BEEF;
               stale_now = 1'b0;
            end
            if (stale_cmd != stale_done) begin
               stale_now  = 1'b1;
               stale_done = stale_cmd;
            end
            if (mem_cnt > 0) begin
               mem_cnt--;
               if (mem_cnt == 0) begin
                  IMemValid = 1'b1;
                  IMemData  = mem_word(mem_addr);
               end
            end
            if (IMemReq) begin
               mem_addr = IMemAddr;
               mem_cnt  = int'($urandom_range(mem_lat_max, mem_lat_min));
            end
         end
      end
   end

   // Monitor and scoreboard: pops expected fetch addresses and checks presented words.
   initial begin : monitor
      logic [31:0] exp_q[$];
      logic [31:0] cur_pc, last_instr, last_pcout, e, nxt;
      bit          outstanding, resp_got, need_push, rst_prev, prev_valid, prev_ready, prev_req;
      int          cyc, resp_cyc, dir_done, tmo_seen;
      cur_pc = 32'h0; last_instr = 32'h0; last_pcout = 32'h0;
      outstanding = 0; resp_got = 0; need_push = 1; rst_prev = 0;
      prev_valid = 0; prev_ready = 0; prev_req = 0;
      cyc = 0; resp_cyc = 0; dir_done = 0; tmo_seen = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (tmo_count != tmo_seen) begin
            checks++;
            errors++;
            $display("FAIL wait_instr_valid: got InstrValid=0 expected 1 within cycle budget");
            tmo_seen = tmo_count;
         end
         if (reset) begin
            exp_q.delete();
            outstanding = 0;
            resp_got    = 0;
            need_push   = 1;
            if (rst_prev) begin
               chk("rst_imemreq", 32'(IMemReq), 32'h0);
               chk("rst_imemaddr", IMemAddr, 32'h0);
               chk("rst_instr", Instr, 32'h0);
               chk("rst_instrvalid", 32'(InstrValid), 32'h0);
               chk("rst_pcout", PCOut, 32'h0);
            end
         end else begin
            if (need_push) begin
               exp_q.push_back(RESET_PC);
               need_push = 0;
            end
            if (IMemValid && outstanding && !resp_got) begin
               resp_got = 1;
               resp_cyc = cyc;
            end
            if (InstrValid && !prev_valid) begin
               chk("resp_before_valid", 32'(resp_got), 32'h1);
               chk("fill_latency", 32'(cyc - resp_cyc), 32'h1);
               outstanding = 0;
            end
            if (InstrValid && prev_valid && !prev_ready) begin
               chk("hold_instr", Instr, last_instr);
               chk("hold_pcout", PCOut, last_pcout);
            end
            if (InstrValid) chk("no_req_in_hold", 32'(IMemReq), 32'h0);
            if (IMemReq) begin
               chk("req_one_cycle", 32'(prev_req), 32'h0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_req: got IMemReq addr %h expected no request", IMemAddr);
               end else begin
                  e = exp_q.pop_front();
                  chk("imem_addr", IMemAddr, e);
                  cur_pc      = e;
                  outstanding = 1;
                  resp_got    = 0;
               end
               if (dir_seq != dir_done) begin
                  chk("directed_addr", IMemAddr, dir_exp);
                  dir_done = dir_seq;
               end
            end
            if (InstrValid && DecReady) begin
               chk("pcout", PCOut, cur_pc);
               chk("instr", Instr, mem_word(cur_pc));
               chk("opcode", 32'(Opcode), mem_word(cur_pc) >> 26);
               nxt = next_fetch(cur_pc, Jump, Branch, Zero, BranchOffset, JumpTarget);
               exp_q.push_back(nxt);
            end
         end
         rst_prev   = reset;
         prev_valid = InstrValid;
         prev_ready = DecReady;
         prev_req   = IMemReq;
         last_instr = Instr;
         last_pcout = PCOut;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!InstrValid && n < 50) begin
         step();
         n++;
      end
      if (!InstrValid) tmo_count++;
   endtask

   task automatic accept(input logic br, input logic z, input logic [15:0] off,
                         input logic j, input logic [25:0] tgt, input logic [31:0] exp_next);
      wait_valid();
      Branch = br; Zero = z; BranchOffset = off; Jump = j; JumpTarget = tgt;
      DecReady = 1'b1;
      dir_exp  = exp_next;
      dir_seq++;
      step();
      DecReady = 1'b0; Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;
      BranchOffset = 16'($urandom);
      JumpTarget   = 26'($urandom);
   endtask

   initial begin : main
      int n;
      reset = 1'b1; DecReady = 1'b0; Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;
      BranchOffset = 16'h0; JumpTarget = 26'h0;
      repeat (3) step();
      reset = 1'b0;

      accept(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h4);
      accept(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h8);
      wait_valid();
      repeat (5) step();
      accept(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'hC);
      accept(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h10);
      accept(1'b1, 1'b1, 16'hFFFE, 1'b0, 26'h0, 32'hC);
      accept(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h10);
      accept(1'b1, 1'b0, 16'hFFFE, 1'b0, 26'h0, 32'h14);
      accept(1'b1, 1'b1, 16'hFFFD, 1'b0, 26'h0, 32'hC);
      accept(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h10);
      accept(1'b1, 1'b1, 16'hFFFE, 1'b1, 26'h40, 32'h100);
      accept(1'b1, 1'b1, 16'hFFBE, 1'b0, 26'h0, 32'hFFFF_FFFC);
      accept(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);

      // Reset while a slow fetch is outstanding, then a stale response right after release.
      mem_lat_min = 3;
      mem_lat_max = 3;
      n = 0;
      while (!IMemReq && n < 20) begin
         step();
         n++;
      end
      step();
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      stale_cmd++;
      dir_exp = RESET_PC;
      dir_seq++;
      mem_lat_min = 1;
      mem_lat_max = 1;
      accept(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h4);

      mem_lat_max = 3;
      for (int i = 0; i < 3000; i++) begin
         DecReady     = 1'($urandom % 2);
         Branch       = 1'($urandom % 2);
         Zero         = 1'($urandom % 2);
         Jump         = ($urandom % 4) == 0;
         BranchOffset = 16'($urandom);
         JumpTarget   = 26'($urandom);
         step();
      end
      DecReady = 1'b0;
      repeat (4) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
